acc_cpu_controller: RTL
=======================

Name: acc_cpu_controller

Overview:
- Multicycle control unit for the 8-bit accumulator CPU datapath: the memory, PC, RI halves, DI, word/data/result registers, the accumulator file, the ALU and the C/Z/N flags.
- A Moore FSM fetches a 2-byte instruction, decodes the 3-bit opcode and issues per-cycle enables and selects to the datapath.
- Also provides a halt indication and a retired-instruction counter.
- Sits beside the datapath inside the CPU top level.

Parameters:
- STORE_CYCLES, 1, cycles mw is held per store (1..15).
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rstN  in  1  synchronous active-low reset
- toCU  in  3  opcode, memory output bits [7:5]
- zFlag  in  1  Z register output
- cFlag  in  1  C register output
- pcEn  out  1  PC write enable
- pcSrc  out  1  PC input select: 0 = PC+1, 1 = RI address
- selAddress  out  1  memory address select: 0 = PC, 1 = RI address
- mr  out  1  memory read
- mw  out  1  memory write
- LSEn  out  1  load left RI half
- RSEn  out  1  load right RI half
- DIEn  out  1  load DI from LS[4:0]
- wordRegEn  out  1  load word register
- dataRegEn  out  1  load data register from accumulator
- resultRegEn  out  1  load result register from ALU
- selData  out  2  accumulator write source: 00 word, 01 result, 10 data
- selAddressAC  out  2  accumulator index source; always 00 (DI[4:3])
- aluOp  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND
- enb  out  1  accumulator write
- CEn  out  1  C flag enable
- ZEn  out  1  Z flag enable
- NEn  out  1  N flag enable
- halted  out  1  high in HALT
- instrCount  out  CNT_WIDTH  retired instructions, wraps

Behaviour:
- Opcodes:
  - 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 AND, 101 JMP, 110 JZ, 111 HLT.
  - Memory operand address is {LS[4:0], RS[7:0]}.
- Reset:
  - rstN sampled low at a clk edge: state <= IF1, opReg <= 0, storeCnt <= 0, instrCount <= 0.
  - While rstN is low, every output strobe and select is forced to 0 and halted = 0.
- Outputs are decoded from state only (Moore). Any output not listed for a state is 0.
- States and transitions:
  - IF1: selAddress=0, mr, LSEn, pcEn, pcSrc=0; opReg <= toCU. Next IF2.
  - IF2: selAddress=0, mr, RSEn, DIEn, pcEn, pcSrc=0. Next DEC.
  - DEC: no strobes. Dispatch on opReg:
    - LDA/ADD/SUB/AND -> RD
    - STA -> ST1
    - JMP -> JMP
    - JZ -> JZ
    - HLT -> HALT
  - RD: selAddress=1, mr, wordRegEn. LDA -> WBW; otherwise -> EXE.
  - EXE: resultRegEn, CEn, ZEn, NEn. aluOp = 00 ADD, 01 SUB, 10 AND. Next WBR.
  - WBW: selData=00, enb. Retire. Next IF1.
  - WBR: selData=01, enb. Retire. Next IF1.
  - ST1: dataRegEn; storeCnt <= 0. Next ST2.
  - ST2: selAddress=1, mw; storeCnt increments each cycle. When storeCnt == STORE_CYCLES-1: retire, next IF1.
  - JMP: pcEn, pcSrc=1, selAddress=1. Retire. Next IF1.
  - JZ: pcEn=zFlag, pcSrc=1, selAddress=1. Retire. Next IF1. zFlag is sampled in this cycle.
  - HALT: halted=1, all strobes 0. Remains until reset. HLT counts as retired on entry.
- Retire: instrCount increments by 1 in the retiring cycle and wraps from all-ones to 0.
- Cycle counts, IF1 to the next IF1: LDA 5, ADD/SUB/AND 6, STA 4+STORE_CYCLES, JMP/JZ 4.
- mr and mw are never high in the same cycle.
- enb is high only in WBW and WBR.
- cFlag is unused in this revision; the port is reserved for JC.
- Reset asserted mid-instruction (for example in ST2) aborts it immediately, with no further mw.

Test Plan:
- Reset, then LDA 0x0123 with mem[0x123]=0x5A -> 5 cycles; enb in the 5th cycle with selData=00; PC advances 2; instrCount=1.
- ADD then SUB sequence -> EXE shows aluOp 00 then 01, with CEn/ZEn/NEn each high for exactly 1 cycle; WBR selData=01; 6 cycles per instruction.
- STA with STORE_CYCLES=3 -> mw high for exactly 3 consecutive cycles with selAddress=1; dataRegEn one cycle earlier; instruction takes 7 cycles.
- JZ with zFlag=0, then JZ with zFlag=1, target 0x1F00 -> pcEn low vs high with pcSrc=1 in the JZ cycle; JMP always loads.
- HLT -> halted=1 on the cycle after DEC and stays high for 20 cycles with no strobes; rstN low for one edge -> IF1 and instrCount=0.
- rstN pulsed low during ST2 -> mw drops in the same cycle; state is IF1 after the edge; counter wrap checked with CNT_WIDTH=2 (4 retires -> 0).

Source files
------------

// File: rtl/acc_cpu_controller.sv
// Multicycle Moore control unit for the 8-bit accumulator CPU: fetches a 2-byte
// instruction, sequences datapath strobes per opcode, flags HALT and counts retires.
module acc_cpu_controller #(
  parameter int STORE_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [2:0]           toCU,
  input  logic                 zFlag,
  input  logic                 cFlag,
  output logic                 pcEn,
  output logic                 pcSrc,
  output logic                 selAddress,
  output logic                 mr,
  output logic                 mw,
  output logic                 LSEn,
  output logic                 RSEn,
  output logic                 DIEn,
  output logic                 wordRegEn,
  output logic                 dataRegEn,
  output logic                 resultRegEn,
  output logic [1:0]           selData,
  output logic [1:0]           selAddressAC,
  output logic [1:0]           aluOp,
  output logic                 enb,
  output logic                 CEn,
  output logic                 ZEn,
  output logic                 NEn,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instrCount,
  output logic [3:0]           state_o
);

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [3:0] STORE_LAST = 4'(STORE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IF1, S_IF2, S_DEC, S_RD, S_EXE, S_WBW, S_WBR,
    S_ST1, S_ST2, S_JMP, S_JZ, S_HALT
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [3:0]           store_cnt_q, store_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 retire;

  // cFlag is reserved for a future conditional-carry jump.
  logic unused_cflag;
  assign unused_cflag = cFlag;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= S_IF1;
      op_q        <= 3'b000;
      store_cnt_q <= 4'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      store_cnt_q <= store_cnt_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    store_cnt_d  = store_cnt_q;
    retire       = 1'b0;
    pcEn         = 1'b0;
    pcSrc        = 1'b0;
    selAddress   = 1'b0;
    mr           = 1'b0;
    mw           = 1'b0;
    LSEn         = 1'b0;
    RSEn         = 1'b0;
    DIEn         = 1'b0;
    wordRegEn    = 1'b0;
    dataRegEn    = 1'b0;
    resultRegEn  = 1'b0;
    selData      = 2'b00;
    selAddressAC = 2'b00;
    aluOp        = 2'b00;
    enb          = 1'b0;
    CEn          = 1'b0;
    ZEn          = 1'b0;
    NEn          = 1'b0;
    halted       = 1'b0;
    // Holding rstN low silences every strobe at once, so a reset mid-store stops mw immediately.
    if (rstN) begin
      case (state_q)
        S_IF1: begin
          mr      = 1'b1;
          LSEn    = 1'b1;
          pcEn    = 1'b1;
          op_d    = toCU;
          state_d = S_IF2;
        end
        S_IF2: begin
          mr      = 1'b1;
          RSEn    = 1'b1;
          DIEn    = 1'b1;
          pcEn    = 1'b1;
          state_d = S_DEC;
        end
        S_DEC: begin
          case (op_q)
            OP_STA:  state_d = S_ST1;
            OP_JMP:  state_d = S_JMP;
            OP_JZ:   state_d = S_JZ;
            OP_HLT: begin
              retire  = 1'b1;
              state_d = S_HALT;
            end
            default: state_d = S_RD;
          endcase
        end
        S_RD: begin
          selAddress = 1'b1;
          mr         = 1'b1;
          wordRegEn  = 1'b1;
          state_d    = (op_q == OP_LDA) ? S_WBW : S_EXE;
        end
        S_EXE: begin
          resultRegEn = 1'b1;
          CEn         = 1'b1;
          ZEn         = 1'b1;
          NEn         = 1'b1;
          case (op_q)
            OP_SUB:  aluOp = 2'b01;
            OP_AND:  aluOp = 2'b10;
            default: aluOp = 2'b00;
          endcase
          state_d = S_WBR;
        end
        S_WBW: begin
          enb     = 1'b1;
          retire  = 1'b1;
          state_d = S_IF1;
        end
        S_WBR: begin
          selData = 2'b01;
          enb     = 1'b1;
          retire  = 1'b1;
          state_d = S_IF1;
        end
        S_ST1: begin
          dataRegEn   = 1'b1;
          store_cnt_d = 4'd0;
          state_d     = S_ST2;
        end
        S_ST2: begin
          selAddress  = 1'b1;
          mw          = 1'b1;
          store_cnt_d = store_cnt_q + 4'd1;
          if (store_cnt_q == STORE_LAST) begin
            retire  = 1'b1;
            state_d = S_IF1;
          end
        end
        S_JMP: begin
          pcEn       = 1'b1;
          pcSrc      = 1'b1;
          selAddress = 1'b1;
          retire     = 1'b1;
          state_d    = S_IF1;
        end
        S_JZ: begin
          pcEn       = zFlag;
          pcSrc      = 1'b1;
          selAddress = 1'b1;
          retire     = 1'b1;
          state_d    = S_IF1;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: state_d = S_IF1;
      endcase
    end
  end

  assign cnt_d      = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  assign instrCount = cnt_q;
  assign state_o    = state_q;

  // The opcode port is consumed only in IF1; OP_ADD and OP_AND fall into the RD default.
  logic [2:0] unused_ops;
  assign unused_ops = OP_ADD ^ OP_AND;

endmodule
